sinc_edge_detector: RTL

//  Parametrised, multi-channel successor to the single-bit sinc rising-edge detector used at the BRAM write front end.

---
 rtl/sinc_edge_pkg.sv | 28 ++
 rtl/sinc_edge_ch.sv | 126 ++++++++++++
 rtl/sinc_edge_detector.sv | 56 +++++
 3 files changed

// File: rtl/sinc_edge_pkg.sv
// Shared encodings for the sinc edge detector.
//   mode_e  : run-time edge selection (rise / fall / both / off)
//   state_e : per-channel holdoff FSM states
//   edge_sel: applies the mode to raw rise/fall detects
package sinc_edge_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic edge_sel(input mode_e m, input logic rise, input logic fall);
    case (m)
      MODE_RISE: return rise;
      MODE_FALL: return fall;
      MODE_BOTH: return rise | fall;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sinc_edge_ch.sv
// One sinc channel: resynchroniser, edge detector, holdoff FSM, sticky miss
// flag and optional accepted-edge counter (SINC_EDGE_CNT_EN).
// Ports:
//   clk, rst         clock, async active-high reset
//   sinc             asynchronous sinc input
//   mode             edge selection (sinc_edge_pkg::mode_e encoding)
//   holdoff          suppression length, sampled on each accepted edge
//   miss_clr/cnt_clr sync clears of the miss flag / edge counter
//   sinc_level       synchronised sinc (last sync stage)
//   sinc_edge        1-clk pulse per accepted edge
//   edge_miss        sticky: edge detected while in holdoff
//   edge_cnt         accepted-edge count (0 when counter not built)
module sinc_edge_ch
  import sinc_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF_W   = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sinc,
  input  logic [1:0]           mode,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 miss_clr,
  input  logic                 cnt_clr,
  output logic                 sinc_level,
  output logic                 sinc_edge,
  output logic                 edge_miss,
  output logic [CNT_W-1:0]     edge_cnt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [HOLDOFF_W-1:0]   r_hcnt;
  logic                   r_edge;
  logic                   r_miss;
  state_e                 r_state;
  state_e                 w_state_nxt;

  logic                   w_s;
  logic                   w_det;
  logic                   w_accept;
  logic                   w_miss_set;
  logic [HOLDOFF_W-1:0]   w_hcnt_nxt;

  // Detect on the last sync stage against its previous value
  assign w_s   = r_sync[SYNC_STAGES-1];
  assign w_det = edge_sel(mode_e'(mode), w_s & ~r_prev, ~w_s & r_prev);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: hcnt==1 is the last suppressed cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_det && (holdoff != '0)) w_state_nxt = ST_HOLD;
      ST_HOLD: if (r_hcnt == HOLDOFF_W'(1)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: accept in IDLE, count down and flag misses in HOLD
  always_comb begin
    w_accept   = 1'b0;
    w_miss_set = 1'b0;
    w_hcnt_nxt = r_hcnt;
    case (r_state)
      ST_IDLE: begin
        if (w_det) begin
          w_accept   = 1'b1;
          w_hcnt_nxt = holdoff;
        end
      end
      ST_HOLD: begin
        w_hcnt_nxt = r_hcnt - HOLDOFF_W'(1);
        w_miss_set = w_det;
      end
      default: ;
    endcase
  end

  // Sync chain, prev, holdoff counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_hcnt <= '0;
      r_edge <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sinc};
      r_prev <= w_s;
      r_hcnt <= w_hcnt_nxt;
      r_edge <= w_accept;
      // A new miss beats a simultaneous clear
      r_miss <= w_miss_set | (r_miss & ~miss_clr);
    end
  end

  assign sinc_level = w_s;
  assign sinc_edge  = r_edge;
  assign edge_miss  = r_miss;

`ifdef SINC_EDGE_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear with a simultaneous accept counts that edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_cnt <= '0;
    else if (cnt_clr)  r_cnt <= CNT_W'(w_accept);
    else if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign edge_cnt = r_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign edge_cnt         = '0;
`endif

endmodule

// File: rtl/sinc_edge_detector.sv
// Multi-channel sinc edge detector: N_CH independent sinc_edge_ch instances.
// Optional per-channel edge counters are built when SINC_EDGE_CNT_EN is
// defined; otherwise edge_cnt reads 0 and cnt_clr is ignored.
// Ports:
//   clk, rst    clock, async active-high reset
//   sinc        N_CH asynchronous sinc inputs
//   mode        00 rise, 01 fall, 10 both, 11 disabled (all channels)
//   holdoff     suppression cycles after an accepted edge
//   miss_clr    sync clear of all edge_miss flags
//   cnt_clr     sync clear of all edge counters
//   sinc_level  synchronised sinc per channel
//   sinc_edge   1-clk pulse per accepted edge
//   edge_miss   sticky miss flags
//   edge_cnt    counts, channel i at [i*CNT_W +: CNT_W]
module sinc_edge_detector
  import sinc_edge_pkg::*;
#(
  parameter int unsigned N_CH        = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF_W   = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       sinc,
  input  logic [1:0]            mode,
  input  logic [HOLDOFF_W-1:0]  holdoff,
  input  logic                  miss_clr,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       sinc_level,
  output logic [N_CH-1:0]       sinc_edge,
  output logic [N_CH-1:0]       edge_miss,
  output logic [N_CH*CNT_W-1:0] edge_cnt
);

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    sinc_edge_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .HOLDOFF_W  (HOLDOFF_W),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sinc      (sinc[g]),
      .mode      (mode),
      .holdoff   (holdoff),
      .miss_clr  (miss_clr),
      .cnt_clr   (cnt_clr),
      .sinc_level(sinc_level[g]),
      .sinc_edge (sinc_edge[g]),
      .edge_miss (edge_miss[g]),
      .edge_cnt  (edge_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule
